adc78h90_scanner: RTL and testbench

- Single-clock SPI master for the ADC78H90 8-channel 12-bit housekeeping ADC (forward/reverse power, PA current, supply voltage).
- Drives the wrapper's ADCCLK/nADCCS/ADCMOSI pins and samples ADCMISO.
- Round-robin scans the channels in an enable mask.
- Presents each conversion to the core's telemetry logic as a one-cycle valid strobe carrying channel number and 12-bit result.

---
 rtl/adc78h90_scanner.sv | 197 +++++++++++++++++++
 tb/tb_adc78h90_scanner.sv | 513 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc78h90_scanner.sv
// adc78h90_scanner: round-robin SPI master for the ADC78H90 housekeeping ADC.
// Each 16-bit frame addresses one enabled channel. The ADC answers with the
// channel addressed in the previous frame, so results are strobed one frame
// late and the first frame after a (re)start is a dummy that only primes the
// pipeline.
module adc78h90_scanner #(
  parameter int CLK_DIV = 4,
  parameter int GAP_CYC = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [7:0]  ch_mask,
  output logic        ADCCLK,
  output logic        nADCCS,
  output logic        ADCMOSI,
  input  logic        ADCMISO,
  output logic        res_valid,
  output logic [2:0]  res_ch,
  output logic [11:0] res_data,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SCLK_LO,
    SCLK_HI,
    CS_HOLD,
    GAP
  } state_t;

  localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);
  localparam logic [7:0] GapLast = 8'(GAP_CYC - 1);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [3:0]  bit_q;
  logic [2:0]  addr_q;
  logic [2:0]  prevAddr_q;
  logic        first_q;
  logic        primed_q;
  logic [11:0] shift_q;
  logic        sclk_q;
  logic        csn_q;
  logic        mosi_q;
  logic        valid_q;
  logic [2:0]  resCh_q;
  logic [11:0] resData_q;
  logic        busy_q;

  logic [2:0]  nextCh_d;
  logic [2:0]  lowestCh;
  logic [2:0]  aboveCh;
  logic        foundAbove;
  logic        launch;
  logic [15:0] mosiWord;
  logic [3:0]  bitDn;

  // Pick the next channel: lowest enabled bit above the last address, else wrap to the lowest.
  always_comb begin
    lowestCh   = 3'd0;
    aboveCh    = 3'd0;
    foundAbove = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (ch_mask[i]) begin
        lowestCh = 3'(i);
        if (3'(i) > addr_q) begin
          aboveCh    = 3'(i);
          foundAbove = 1'b1;
        end
      end
    end
    nextCh_d = (first_q || !foundAbove) ? lowestCh : aboveCh;
  end

  // A frame starts from IDLE or straight out of the last GAP cycle, so continuous scans have no idle cycles.
  assign launch   = enable && (ch_mask != 8'd0) &&
                    ((state_q == IDLE) || ((state_q == GAP) && (cnt_q == GapLast)));
  assign mosiWord = {2'b00, addr_q, 11'd0};
  assign bitDn    = bit_q - 4'd1;

  // Frame sequencer; the latched address is the frame-local copy of the mask decision, and all pins are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      bit_q      <= 4'd0;
      addr_q     <= 3'd0;
      prevAddr_q <= 3'd0;
      first_q    <= 1'b1;
      primed_q   <= 1'b0;
      shift_q    <= 12'd0;
      sclk_q     <= 1'b1;
      csn_q      <= 1'b1;
      mosi_q     <= 1'b0;
      valid_q    <= 1'b0;
      resCh_q    <= 3'd0;
      resData_q  <= 12'd0;
      busy_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (launch) begin
        state_q    <= CS_SETUP;
        cnt_q      <= 8'd0;
        prevAddr_q <= addr_q;
        addr_q     <= nextCh_d;
        first_q    <= 1'b0;
        csn_q      <= 1'b0;
        sclk_q     <= 1'b1;
        busy_q     <= 1'b1;
      end else begin
        unique case (state_q)
          IDLE: begin
            primed_q <= 1'b0;
            busy_q   <= 1'b0;
          end
          CS_SETUP: begin
            if (cnt_q == DivLast) begin
              state_q <= SCLK_LO;
              cnt_q   <= 8'd0;
              bit_q   <= 4'd15;
              sclk_q  <= 1'b0;
              mosi_q  <= mosiWord[15];
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          SCLK_LO: begin
            if (cnt_q == DivLast) begin
              state_q <= SCLK_HI;
              cnt_q   <= 8'd0;
              sclk_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          SCLK_HI: begin
            if (cnt_q == 8'd0) begin
              shift_q <= {shift_q[10:0], ADCMISO};
            end
            if (cnt_q == DivLast) begin
              cnt_q <= 8'd0;
              if (bit_q == 4'd0) begin
                state_q <= CS_HOLD;
              end else begin
                state_q <= SCLK_LO;
                bit_q   <= bitDn;
                sclk_q  <= 1'b0;
                mosi_q  <= mosiWord[bitDn];
              end
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          CS_HOLD: begin
            if (cnt_q == DivLast) begin
              state_q  <= GAP;
              cnt_q    <= 8'd0;
              csn_q    <= 1'b1;
              primed_q <= 1'b1;
              if (primed_q) begin
                valid_q   <= 1'b1;
                resCh_q   <= prevAddr_q;
                resData_q <= shift_q;
              end
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          GAP: begin
            if (cnt_q == GapLast) begin
              state_q  <= IDLE;
              cnt_q    <= 8'd0;
              primed_q <= 1'b0;
              busy_q   <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign ADCCLK    = sclk_q;
  assign nADCCS    = csn_q;
  assign ADCMOSI   = mosi_q;
  assign res_valid = valid_q;
  assign res_ch    = resCh_q;
  assign res_data  = resData_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_adc78h90_scanner.sv
// tb_adc78h90_scanner: bench for the ADC78H90 scanner with a behavioural ADC,
// a bus monitor and a scoreboard of expected (channel, data) results.
module tb_adc78h90_scanner;

  localparam int CLK_DIV = 4;
  localparam int GAP_CYC = 8;
  localparam int FRAME   = CLK_DIV * 34 + GAP_CYC;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        en    = 1'b0;
  logic [7:0]  mask  = 8'd0;
  logic        miso  = 1'b0;
  logic        sclk;
  logic        csn;
  logic        mosi;
  logic        resValid;
  logic [2:0]  resCh;
  logic [11:0] resData;
  logic        busy;

  adc78h90_scanner #(.CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (en),
    .ch_mask  (mask),
    .ADCCLK   (sclk),
    .nADCCS   (csn),
    .ADCMOSI  (mosi),
    .ADCMISO  (miso),
    .res_valid(resValid),
    .res_ch   (resCh),
    .res_data (resData),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  ch;
    logic [11:0] data;
  } exp_t;

  exp_t        expQ[$];
  int          testsRun = 0;
  int          testsFailed = 0;
  int          frameCnt = 0;
  int          strobeCnt = 0;
  int          fallCnt = 0;
  int          cyc = 0;
  int          lastStrobeCyc = -1;
  bit          monOn = 1'b0;
  bit          inFrame = 1'b0;
  bit          tbFirst = 1'b1;
  logic [2:0]  tbPrev = 3'd0;
  logic [2:0]  expCh = 3'd0;
  logic [2:0]  lastStrobeCh = 3'd0;
  logic [11:0] lastStrobeData = 12'd0;
  logic [3:0]  leadNib = 4'h0;
  bit          constData = 1'b1;

  // ADC model state
  logic        adcPrevCs = 1'b1;
  logic        adcPrevClk = 1'b1;
  logic [15:0] adcWord = 16'd0;
  logic [15:0] adcCap = 16'd0;
  logic [2:0]  adcAddr = 3'd0;
  int          adcFall = 0;

  function automatic logic [11:0] dataFn(input logic [2:0] ch);
    return constData ? 12'hABC : (12'h100 + {9'd0, ch});
  endfunction

  function automatic logic [2:0] modelNext(input logic [7:0] m, input logic [2:0] prev, input bit first);
    logic [2:0] lo = 3'd0;
    bit haveLo = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (m[c] && !haveLo) begin
        lo = 3'(c);
        haveLo = 1'b1;
      end
    end
    if (first) return lo;
    for (int c = int'(prev) + 1; c < 8; c++) begin
      if (m[c]) return 3'(c);
    end
    return lo;
  endfunction

  // Behavioural ADC: returns the previously addressed channel, DOUT changes on falling SCLK
  always @(csn or sclk) begin
    if (adcPrevCs === 1'b1 && csn === 1'b0) begin
      adcWord = {leadNib, dataFn(adcAddr)};
      miso    = adcWord[15];
      adcFall = 0;
      adcCap  = 16'd0;
    end else if (adcPrevCs === 1'b0 && csn === 1'b1) begin
      adcAddr = adcCap[13:11];
    end else if (csn === 1'b0) begin
      if (adcPrevClk === 1'b1 && sclk === 1'b0) begin
        if (adcFall > 0 && adcFall < 16) miso = adcWord[15 - adcFall];
        adcFall++;
      end else if (adcPrevClk === 1'b0 && sclk === 1'b1) begin
        adcCap = {adcCap[14:0], mosi};
      end
    end
    adcPrevCs  = csn;
    adcPrevClk = sclk;
  end

  task automatic flushScoreboard();
    expQ.delete();
    lastStrobeCyc = -1;
  endtask

  // Bus monitor and scoreboard consumer, sampled 1 ns after each rising clk edge
  task automatic monitor();
    logic        prevCs = 1'b1;
    logic        prevSclk = 1'b1;
    logic        prevMosi = 1'b0;
    logic        prevValid = 1'b0;
    bit          csRose;
    int          csLow = 0;
    int          runLen = 0;
    logic [15:0] monShift = 16'd0;
    logic [15:0] expWord;
    exp_t        e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      csRose = 1'b0;
      if (!monOn) begin
        inFrame   = 1'b0;
        prevValid = 1'b0;
      end else begin
        if (prevValid) begin
          testsRun++;
          if (resValid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL strobe_width: res_valid=%b, required 0 one cycle after strobe", resValid);
          end
        end
        if (prevCs === 1'b1 && csn === 1'b0) begin
          inFrame  = 1'b1;
          expCh    = modelNext(mask, tbPrev, tbFirst);
          tbPrev   = expCh;
          tbFirst  = 1'b0;
          csLow    = 0;
          fallCnt  = 0;
          runLen   = 0;
          monShift = 16'd0;
        end
        if (inFrame && csn === 1'b0) begin
          csLow++;
          if (prevSclk === 1'b1 && sclk === 1'b0) begin
            testsRun++;
            if (runLen != CLK_DIV) begin
              testsFailed++;
              $display("[TB] FAIL sclk_high_len: %0d cycles, required %0d", runLen, CLK_DIV);
            end
            fallCnt++;
            runLen = 0;
          end else if (prevSclk === 1'b0 && sclk === 1'b1) begin
            testsRun++;
            if (runLen != CLK_DIV || mosi !== prevMosi) begin
              testsFailed++;
              $display("[TB] FAIL sclk_low_len_mosi: low %0d (req %0d), mosi %b (req stable %b)",
                       runLen, CLK_DIV, mosi, prevMosi);
            end
            monShift = {monShift[14:0], mosi};
            runLen = 0;
          end
          runLen++;
        end
        if (inFrame && prevCs === 1'b0 && csn === 1'b1) begin
          expWord = {2'b00, expCh, 11'd0};
          testsRun++;
          if (csLow != CLK_DIV * 34 || fallCnt != 16 || monShift !== expWord) begin
            testsFailed++;
            $display("[TB] FAIL frame_shape: cs_low %0d falls %0d mosi %h, required %0d 16 %h",
                     csLow, fallCnt, monShift, CLK_DIV * 34, expWord);
          end
          e.ch   = expCh;
          e.data = dataFn(expCh);
          expQ.push_back(e);
          frameCnt++;
          inFrame = 1'b0;
          csRose  = 1'b1;
        end
        if (resValid === 1'b1) begin
          strobeCnt++;
          lastStrobeCh   = resCh;
          lastStrobeData = resData;
          testsRun++;
          if (!csRose) begin
            testsFailed++;
            $display("[TB] FAIL strobe_timing: strobe not on first GAP cycle (cs=%b)", csn);
          end
          testsRun++;
          if (expQ.size() < 2) begin
            testsFailed++;
            $display("[TB] FAIL unexpected_strobe: ch %0d data %h, required no strobe", resCh, resData);
          end else begin
            e = expQ.pop_front();
            if (resCh !== e.ch || resData !== e.data) begin
              testsFailed++;
              $display("[TB] FAIL result: ch %0d data %h, required ch %0d data %h",
                       resCh, resData, e.ch, e.data);
            end
          end
          if (lastStrobeCyc >= 0) begin
            testsRun++;
            if (cyc - lastStrobeCyc != FRAME) begin
              testsFailed++;
              $display("[TB] FAIL strobe_period: %0d cycles, required %0d", cyc - lastStrobeCyc, FRAME);
            end
          end
          lastStrobeCyc = cyc;
        end
        prevValid = resValid;
      end
      prevCs   = csn;
      prevSclk = sclk;
      prevMosi = mosi;
    end
  endtask

  task automatic waitFrames(input int target, output bit ok);
    int n = 0;
    while (frameCnt < target && n < 20 * FRAME) begin
      @(posedge clk);
      #2;
      n++;
    end
    ok = (frameCnt >= target);
  endtask

  task automatic waitIdle(output bit ok);
    int n = 0;
    while ((busy !== 1'b0 || csn !== 1'b1) && n < 3 * FRAME) begin
      @(posedge clk);
      #2;
      n++;
    end
    ok = (busy === 1'b0 && csn === 1'b1);
  endtask

  task automatic test_reset();
    #3;
    rst_n = 1'b0;
    #1;
    testsRun++;
    if (sclk !== 1'b1 || csn !== 1'b1 || mosi !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_pins: sclk %b cs %b mosi %b, required 1 1 0", sclk, csn, mosi);
    end
    testsRun++;
    if (resValid !== 1'b0 || resCh !== 3'd0 || resData !== 12'd0 || busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_result: valid %b ch %0d data %h busy %b, required 0 0 000 0",
               resValid, resCh, resData, busy);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    monOn = 1'b1;
  endtask

  task automatic test_single_channel();
    bit ok;
    int f0;
    @(negedge clk);
    constData = 1'b1;
    mask = 8'h01;
    flushScoreboard();
    f0 = frameCnt;
    en = 1'b1;
    waitFrames(f0 + 1, ok);
    testsRun++;
    if (!ok || strobeCnt != 0) begin
      testsFailed++;
      $display("[TB] FAIL dummy_frame: ok %b strobes %0d, required 1 0", ok, strobeCnt);
    end
    waitFrames(f0 + 4, ok);
    testsRun++;
    if (!ok || strobeCnt != 3 || lastStrobeData !== 12'hABC) begin
      testsFailed++;
      $display("[TB] FAIL single_strobes: ok %b strobes %0d data %h, required 1 3 abc", ok, strobeCnt, lastStrobeData);
    end
    en = 1'b0;
    waitIdle(ok);
    testsRun++;
    if (!ok) begin
      testsFailed++;
      $display("[TB] FAIL single_idle: busy %b cs %b, required 0 1", busy, csn);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int f0, s0;
    @(negedge clk);
    constData = 1'b0;
    mask = 8'hA5;
    flushScoreboard();
    f0 = frameCnt;
    s0 = strobeCnt;
    en = 1'b1;
    waitFrames(f0 + 9, ok);
    testsRun++;
    if (!ok || strobeCnt - s0 != 8) begin
      testsFailed++;
      $display("[TB] FAIL rr_strobes: ok %b strobes %0d, required 1 8", ok, strobeCnt - s0);
    end
    en = 1'b0;
    waitIdle(ok);
    testsRun++;
    if (!ok) begin
      testsFailed++;
      $display("[TB] FAIL rr_idle: busy %b cs %b, required 0 1", busy, csn);
    end
  endtask

  task automatic test_spi_timing();
    bit ok;
    int f0, s0;
    @(negedge clk);
    constData = 1'b0;
    leadNib = 4'hF;
    mask = 8'h10;
    flushScoreboard();
    f0 = frameCnt;
    s0 = strobeCnt;
    en = 1'b1;
    waitFrames(f0 + 3, ok);
    testsRun++;
    if (!ok || strobeCnt - s0 != 2 || lastStrobeData !== 12'h104 || lastStrobeCh !== 3'd4) begin
      testsFailed++;
      $display("[TB] FAIL lead_ignored: strobes %0d ch %0d data %h, required 2 4 104",
               strobeCnt - s0, lastStrobeCh, lastStrobeData);
    end
    en = 1'b0;
    waitIdle(ok);
    leadNib = 4'h0;
    testsRun++;
    if (!ok) begin
      testsFailed++;
      $display("[TB] FAIL timing_idle: busy %b cs %b, required 0 1", busy, csn);
    end
  endtask

  task automatic test_enable_drop();
    bit ok;
    int f0, f1, s0, n, busyLen;
    @(negedge clk);
    constData = 1'b0;
    mask = 8'h06;
    flushScoreboard();
    f0 = frameCnt;
    en = 1'b1;
    waitFrames(f0 + 2, ok);
    n = 0;
    while (!(inFrame && fallCnt == 9) && n < 2 * FRAME) begin
      @(posedge clk);
      #2;
      n++;
    end
    testsRun++;
    if (!ok || !(inFrame && fallCnt == 9)) begin
      testsFailed++;
      $display("[TB] FAIL drop_reach_bit7: ok %b falls %0d, required 1 9", ok, fallCnt);
    end
    en = 1'b0;
    s0 = strobeCnt;
    f1 = frameCnt;
    n = 0;
    while (csn !== 1'b1 && n < FRAME) begin
      @(posedge clk);
      #2;
      n++;
    end
    busyLen = 0;
    while (busy === 1'b1 && busyLen < 4 * GAP_CYC) begin
      busyLen++;
      @(posedge clk);
      #2;
    end
    testsRun++;
    if (busyLen != GAP_CYC || strobeCnt != s0 + 1 || frameCnt != f1 + 1) begin
      testsFailed++;
      $display("[TB] FAIL drop_complete: busy gap %0d strobes %0d frames %0d, required %0d 1 1",
               busyLen, strobeCnt - s0, frameCnt - f1, GAP_CYC);
    end
    repeat (2 * GAP_CYC) @(posedge clk);
    #2;
    testsRun++;
    if (csn !== 1'b1 || busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL drop_stays_idle: cs %b busy %b, required 1 0", csn, busy);
    end
    flushScoreboard();
    f0 = frameCnt;
    s0 = strobeCnt;
    en = 1'b1;
    waitFrames(f0 + 1, ok);
    testsRun++;
    if (!ok || strobeCnt != s0) begin
      testsFailed++;
      $display("[TB] FAIL reenable_dummy: ok %b strobes %0d, required 1 0", ok, strobeCnt - s0);
    end
    waitFrames(f0 + 2, ok);
    testsRun++;
    if (!ok || strobeCnt != s0 + 1) begin
      testsFailed++;
      $display("[TB] FAIL reenable_strobe: ok %b strobes %0d, required 1 1", ok, strobeCnt - s0);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int f0, s0, n;
    n = 0;
    while (!(inFrame && sclk === 1'b0) && n < 2 * FRAME) begin
      @(posedge clk);
      #2;
      n++;
    end
    @(negedge clk);
    monOn = 1'b0;
    rst_n = 1'b0;
    #1;
    testsRun++;
    if (n >= 2 * FRAME || sclk !== 1'b1 || csn !== 1'b1 || resValid !== 1'b0 || busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL async_reset: wait %0d sclk %b cs %b valid %b busy %b, required <%0d 1 1 0 0",
               n, sclk, csn, resValid, busy, 2 * FRAME);
    end
    repeat (3) @(negedge clk);
    tbFirst = 1'b1;
    mask = 8'h12;
    flushScoreboard();
    f0 = frameCnt;
    s0 = strobeCnt;
    monOn = 1'b1;
    rst_n = 1'b1;
    waitFrames(f0 + 1, ok);
    testsRun++;
    if (!ok || strobeCnt != s0) begin
      testsFailed++;
      $display("[TB] FAIL post_reset_dummy: ok %b strobes %0d, required 1 0", ok, strobeCnt - s0);
    end
    waitFrames(f0 + 2, ok);
    testsRun++;
    if (!ok || strobeCnt != s0 + 1 || lastStrobeCh !== 3'd1) begin
      testsFailed++;
      $display("[TB] FAIL post_reset_strobe: strobes %0d ch %0d, required 1 1", strobeCnt - s0, lastStrobeCh);
    end
  endtask

  task automatic test_zero_mask();
    bit ok;
    int f0, s0, bad;
    @(negedge clk);
    en = 1'b0;
    waitIdle(ok);
    mask = 8'h00;
    en = 1'b1;
    bad = 0;
    repeat (2 * FRAME) begin
      @(posedge clk);
      #2;
      if (csn !== 1'b1 || busy !== 1'b0) bad++;
    end
    testsRun++;
    if (!ok || bad != 0) begin
      testsFailed++;
      $display("[TB] FAIL zero_mask_idle: ok %b active cycles %0d, required 1 0", ok, bad);
    end
    flushScoreboard();
    f0 = frameCnt;
    s0 = strobeCnt;
    mask = 8'h80;
    waitFrames(f0 + 2, ok);
    testsRun++;
    if (!ok || strobeCnt != s0 + 1 || lastStrobeCh !== 3'd7) begin
      testsFailed++;
      $display("[TB] FAIL mask_80: ok %b strobes %0d ch %0d, required 1 1 7", ok, strobeCnt - s0, lastStrobeCh);
    end
    en = 1'b0;
    waitIdle(ok);
    testsRun++;
    if (!ok) begin
      testsFailed++;
      $display("[TB] FAIL final_idle: busy %b cs %b, required 0 1", busy, csn);
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_single_channel();
    test_round_robin();
    test_spi_timing();
    test_enable_drop();
    test_reset_mid_frame();
    test_zero_mask();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
